// File: rtl/blink_period_meter_if.sv
// blink_period_meter_if: measured input wave and result bus of the blink period meter.
interface blink_period_meter_if #(parameter int WIDTH = 26);
  logic             sig_in;
  logic [WIDTH-1:0] high_count;
  logic [WIDTH-1:0] low_count;
  logic [WIDTH:0]   period;
  logic             meas_valid;
  logic             ovf;
  logic             LED0;
  modport master (output sig_in, input high_count, low_count, period, meas_valid, ovf, LED0);
  modport slave  (input sig_in, output high_count, low_count, period, meas_valid, ovf, LED0);
endinterface

// File: rtl/blink_period_meter.sv
// blink_period_meter: synchronises a square wave and reports high time, low time and
// period of each complete cycle in clock ticks, with saturation flag and lock LED.
module blink_period_meter #(
  parameter int WIDTH       = 26,
  parameter int SYNC_STAGES = 2
) (
  input logic                 CLK50M,
  input logic                 reset,
  blink_period_meter_if.slave bus
);
  localparam logic [WIDTH-1:0] MAX    = '1;
  localparam logic [WIDTH-1:0] SETTLE = WIDTH'(SYNC_STAGES);
  typedef enum logic [1:0] {WAIT_LOW, WAIT_RISE, MEAS_HIGH, MEAS_LOW} state_t;
  state_t               state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                 sig_d_q;
  logic [WIDTH-1:0]     cnt_q, cnt_d, hi_lat_q, hi_lat_d, high_q, high_d, low_q, low_d;
  logic [WIDTH:0]       period_q, period_d;
  logic                 hi_sat_q, hi_sat_d, ovf_q, ovf_d, mv_q, mv_d, led_q, led_d;
  logic                 sig_s, rise, fall, new_ovf;
  logic [WIDTH-1:0]     cnt_inc;
  assign sig_s   = sync_q[SYNC_STAGES-1];
  assign rise    = sig_s & ~sig_d_q;
  assign fall    = ~sig_s & sig_d_q;
  assign cnt_inc = (cnt_q == MAX) ? MAX : cnt_q + 1'b1;
  assign new_ovf = hi_sat_q | (cnt_q == MAX);
  always_ff @(posedge CLK50M or negedge reset) begin
    if (!reset) begin
      state_q  <= WAIT_LOW;
      sync_q   <= '0;
      sig_d_q  <= 1'b0;
      cnt_q    <= '0;
      hi_lat_q <= '0;
      hi_sat_q <= 1'b0;
      high_q   <= '0;
      low_q    <= '0;
      period_q <= '0;
      ovf_q    <= 1'b0;
      mv_q     <= 1'b0;
      led_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sync_q   <= {sync_q[SYNC_STAGES-2:0], bus.sig_in};
      sig_d_q  <= sig_s;
      cnt_q    <= cnt_d;
      hi_lat_q <= hi_lat_d;
      hi_sat_q <= hi_sat_d;
      high_q   <= high_d;
      low_q    <= low_d;
      period_q <= period_d;
      ovf_q    <= ovf_d;
      mv_q     <= mv_d;
      led_q    <= led_d;
    end
  end
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_lat_d = hi_lat_q;
    hi_sat_d = hi_sat_q;
    high_d   = high_q;
    low_d    = low_q;
    period_d = period_q;
    ovf_d    = ovf_q;
    mv_d     = 1'b0;
    led_d    = led_q;
    case (state_q)
      // cnt doubles as a settle timer so a level still in the synchroniser is not mistaken for low
      WAIT_LOW: begin
        cnt_d   = cnt_inc;
        state_d = (cnt_q >= SETTLE && !sig_s) ? WAIT_RISE : WAIT_LOW;
      end
      WAIT_RISE: begin
        cnt_d   = rise ? WIDTH'(1) : cnt_q;
        state_d = rise ? MEAS_HIGH : WAIT_RISE;
      end
      MEAS_HIGH: begin
        cnt_d    = fall ? WIDTH'(1) : cnt_inc;
        hi_lat_d = fall ? cnt_q : hi_lat_q;
        hi_sat_d = fall ? (cnt_q == MAX) : hi_sat_q;
        state_d  = fall ? MEAS_LOW : MEAS_HIGH;
      end
      default: begin
        cnt_d   = rise ? WIDTH'(1) : cnt_inc;
        state_d = rise ? MEAS_HIGH : MEAS_LOW;
        if (rise) begin
          high_d   = hi_lat_q;
          low_d    = cnt_q;
          period_d = {1'b0, hi_lat_q} + {1'b0, cnt_q};
          ovf_d    = new_ovf;
          mv_d     = 1'b1;
          led_d    = ~new_ovf;
        end
      end
    endcase
  end
  assign bus.high_count = high_q;
  assign bus.low_count  = low_q;
  assign bus.period     = period_q;
  assign bus.meas_valid = mv_q;
  assign bus.ovf        = ovf_q;
  assign bus.LED0       = led_q;
endmodule
